// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sequencer
//  Description : Front-end controller that reads a stored image from a
//                1-cycle-latency memory in raster order and presents it as a
//                Frame/Line/PixelValid stream with line and frame blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int COLS   = 128,
    parameter int ROWS   = 128,
    parameter int HBLANK = 4,
    parameter int VBLANK = 16,
    parameter int ADDR_W = 14
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Hold,
    input  logic [7:0]        NumFrames,
    output logic              RdEn,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              PixelValid,
    output logic              Frame,
    output logic              Line,
    output logic [7:0]        i,
    output logic [7:0]        j,
    output logic              Busy,
    output logic              Done,
    output logic [7:0]        FrameCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    localparam logic [7:0]        COL_LAST = 8'(COLS - 1);
    localparam logic [7:0]        ROW_LAST = 8'(ROWS - 1);
    // Blank timers count down from N-1 so each blank state lasts exactly N cycles
    localparam logic [15:0]       HB_LOAD  = 16'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [15:0]       VB_LOAD  = 16'((VBLANK > 0) ? VBLANK - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        col;
    logic [7:0]        row;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       blank_cnt;
    logic [7:0]        num_frames;
    logic              stop_pending;

    logic              start_ok;
    logic              line_end;
    logic              frame_end;
    logic              last_frame;
    logic              blank_done;
    logic [7:0]        frame_count_inc;

    assign start_ok        = Start && !Stop;
    assign line_end        = (col == COL_LAST);
    assign frame_end       = line_end && (row == ROW_LAST);
    assign blank_done      = (blank_cnt == 16'd0);
    assign frame_count_inc = (FrameCount == 8'hFF) ? 8'hFF : FrameCount + 8'd1;
    // A live Stop on the last pixel counts too: the frame is complete at that point
    assign last_frame      = ((num_frames != 8'd0) &&
                              (({1'b0, FrameCount} + 9'd1) == {1'b0, num_frames}))
                             || stop_pending || Stop;

    assign RdEn   = (state == ST_ACTIVE) && !Hold;
    assign RdAddr = addr;
    assign Busy   = (state != ST_IDLE);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; Hold freezes every transition out of the run states
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!Hold && line_end) begin
                    if (frame_end) begin
                        if (last_frame) begin
                            state_next = ST_IDLE;
                        end else if (VBLANK == 0) begin
                            state_next = ST_ACTIVE;
                        end else begin
                            state_next = ST_VBLANK;
                        end
                    end else if (HBLANK == 0) begin
                        state_next = ST_ACTIVE;
                    end else begin
                        state_next = ST_HBLANK;
                    end
                end
            end
            ST_HBLANK, ST_VBLANK: begin
                if (!Hold && blank_done) begin
                    state_next = ST_ACTIVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Raster counters, run bookkeeping and the output stage aligned to read data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            col          <= 8'd0;
            row          <= 8'd0;
            addr         <= '0;
            blank_cnt    <= 16'd0;
            num_frames   <= 8'd0;
            stop_pending <= 1'b0;
            PixelValid   <= 1'b0;
            Frame        <= 1'b0;
            Line         <= 1'b0;
            i            <= 8'd0;
            j            <= 8'd0;
            Done         <= 1'b0;
            FrameCount   <= 8'd0;
        end else begin
            PixelValid <= RdEn;
            Frame      <= RdEn && (col == 8'd0) && (row == 8'd0);
            Line       <= RdEn && (col == 8'd0);
            Done       <= 1'b0;
            if (RdEn) begin
                i <= col;
                j <= row;
            end

            if (state == ST_IDLE) begin
                if (start_ok) begin
                    num_frames   <= NumFrames;
                    col          <= 8'd0;
                    row          <= 8'd0;
                    addr         <= '0;
                    FrameCount   <= 8'd0;
                    stop_pending <= 1'b0;
                end
            end else if (Stop) begin
                stop_pending <= 1'b1;
            end

            if (RdEn) begin
                if (line_end) begin
                    // Row advances at line end; blanking only delays the next fetch
                    col <= 8'd0;
                    if (frame_end) begin
                        row        <= 8'd0;
                        addr       <= '0;
                        blank_cnt  <= VB_LOAD;
                        FrameCount <= frame_count_inc;
                        Done       <= last_frame;
                    end else begin
                        row       <= row + 8'd1;
                        addr      <= addr + ADDR_ONE;
                        blank_cnt <= HB_LOAD;
                    end
                end else begin
                    col  <= col + 8'd1;
                    addr <= addr + ADDR_ONE;
                end
            end

            if (((state == ST_HBLANK) || (state == ST_VBLANK)) && !Hold && !blank_done) begin
                blank_cnt <= blank_cnt - 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sequencer
//  Description : Directed self-checking bench for frame_sequencer on a 4x3
//                image with HBLANK=2 and VBLANK=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int COLS   = 4;
    localparam int ROWS   = 3;
    localparam int HBLANK = 2;
    localparam int VBLANK = 3;
    localparam int ADDR_W = 14;
    localparam int NPIX   = COLS * ROWS;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              hold;
    logic [7:0]        num_frames;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              pixel_valid;
    logic              frame;
    logic              line;
    logic [7:0]        i;
    logic [7:0]        j;
    logic              busy;
    logic              done;
    logic [7:0]        frame_count;

    frame_sequencer #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .HBLANK (HBLANK),
        .VBLANK (VBLANK),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clk        (clk),
        .Reset      (reset),
        .Start      (start),
        .Stop       (stop),
        .Hold       (hold),
        .NumFrames  (num_frames),
        .RdEn       (rd_en),
        .RdAddr     (rd_addr),
        .PixelValid (pixel_valid),
        .Frame      (frame),
        .Line       (line),
        .i          (i),
        .j          (j),
        .Busy       (busy),
        .Done       (done),
        .FrameCount (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observation log, filled once per cycle at the falling edge
    int          cyc_idx;
    int          first_rd;
    int          first_pv;
    int          rd_q[$];
    logic [15:0] px_q[$];
    int          gap_q[$];
    int          gap;
    bit          seen_pv;
    int          n_frame;
    int          n_line;
    int          n_done;
    int          frame_bad;
    int          line_bad;
    logic [15:0] done_px;
    bit          busy_at_done;
    bit          last_rd;
    int          last_addr;
    int          exp_g[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        cyc_idx = -1; first_rd = -1; first_pv = -1;
        rd_q.delete(); px_q.delete(); gap_q.delete();
        gap = 0; seen_pv = 0; n_frame = 0; n_line = 0; n_done = 0;
        frame_bad = 0; line_bad = 0; done_px = 16'hFFFF; busy_at_done = 0;
        last_rd = 0; last_addr = -1;
    endtask

    // One clock: sample at the falling edge, return 1 time unit after the rising edge
    task automatic cycle();
        @(negedge clk);
        cyc_idx++;
        last_rd   = rd_en;
        last_addr = int'(rd_addr);
        if (rd_en) begin
            if (first_rd < 0) first_rd = cyc_idx;
            rd_q.push_back(int'(rd_addr));
        end
        if (pixel_valid) begin
            if (first_pv < 0) first_pv = cyc_idx;
            px_q.push_back({j, i});
            if (seen_pv && gap > 0) gap_q.push_back(gap);
            gap = 0;
            seen_pv = 1;
        end else if (seen_pv) begin
            gap++;
        end
        if (frame) begin
            n_frame++;
            if (!(pixel_valid && i == 8'd0 && j == 8'd0)) frame_bad++;
        end
        if (line) begin
            n_line++;
            if (!(pixel_valid && i == 8'd0)) line_bad++;
        end
        if (done) begin
            n_done++;
            done_px = {j, i};
            if (busy) busy_at_done = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] nf);
        num_frames = nf;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Step a run to completion, optionally pulsing Stop/Start at an address
    // or holding for hold_len cycles after a given address was read
    task automatic run(input int max_cyc, input int stop_addr, input int hold_addr,
                       input int hold_len, input int start_addr);
        bit stopped = 0;
        bit held    = 0;
        bit fin     = 0;
        int n       = 0;
        while (n < max_cyc && !fin) begin
            stop = (stop_addr >= 0 && !stopped && rd_en && int'(rd_addr) == stop_addr);
            if (stop) stopped = 1;
            start = (start_addr >= 0 && rd_en && int'(rd_addr) == start_addr);
            cycle();
            n++;
            stop  = 1'b0;
            start = 1'b0;
            if (hold_addr >= 0 && !held && last_rd && last_addr == hold_addr) begin
                hold = 1'b1;
                repeat (hold_len) begin
                    cycle();
                    n++;
                end
                hold = 1'b0;
                held = 1;
            end
            if (!busy) begin
                cycle();
                fin = 1;
            end
        end
        if (!fin) check_value("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_log(input string t, input int n_rd, input int n_fr,
                             input int n_dn, input int fc);
        int bad;
        check_value({t, "_rd_count"}, rd_q.size(), n_rd);
        bad = 0;
        foreach (rd_q[k]) if (rd_q[k] != k % NPIX) bad++;
        check_value({t, "_rd_addr_seq"}, bad, 0);
        check_value({t, "_px_count"}, px_q.size(), n_rd);
        bad = 0;
        foreach (px_q[k]) if (px_q[k] != {8'((k / COLS) % ROWS), 8'(k % COLS)}) bad++;
        check_value({t, "_px_ij_seq"}, bad, 0);
        check_value({t, "_frames"}, n_frame, n_fr);
        check_value({t, "_lines"}, n_line, n_rd / COLS);
        check_value({t, "_frame_align"}, frame_bad, 0);
        check_value({t, "_line_align"}, line_bad, 0);
        check_value({t, "_gap_count"}, gap_q.size(), exp_g.size());
        for (int k = 0; k < exp_g.size() && k < gap_q.size(); k++)
            check_value($sformatf("%s_gap%0d", t, k), gap_q[k], exp_g[k]);
        check_value({t, "_done_count"}, n_done, n_dn);
        check_value({t, "_done_px"}, done_px, (n_dn > 0) ? 32'h0203 : 32'hFFFF);
        check_value({t, "_busy_at_done"}, busy_at_done, 0);
        check_value({t, "_frame_count"}, frame_count, fc);
        check_value({t, "_busy_end"}, busy, 0);
    endtask

    task automatic check_all_zero(input string t);
        check_value({t, "_rd_en"}, rd_en, 0);
        check_value({t, "_rd_addr"}, rd_addr, 0);
        check_value({t, "_pixel_valid"}, pixel_valid, 0);
        check_value({t, "_frame"}, frame, 0);
        check_value({t, "_line"}, line, 0);
        check_value({t, "_i"}, i, 0);
        check_value({t, "_j"}, j, 0);
        check_value({t, "_busy"}, busy, 0);
        check_value({t, "_done"}, done, 0);
        check_value({t, "_frame_count"}, frame_count, 0);
    endtask

    initial begin
        bit found;
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; num_frames = 8'd0;
        clear_log();
        repeat (3) cycle();
        check_all_zero("reset");
        reset = 1'b0;
        cycle();

        // 1: single frame, latency and line blanking
        clear_log();
        pulse_start(8'd1);
        run(200, -1, -1, 0, -1);
        check_value("t1_first_rd_cycle", first_rd, 1);
        check_value("t1_first_pv_cycle", first_pv, 2);
        exp_g = {2, 2};
        check_log("t1", 12, 1, 1, 1);

        // 2: two frames with frame blanking; a Start mid-run must be ignored
        clear_log();
        pulse_start(8'd2);
        check_value("t2_fc_cleared", frame_count, 0);
        check_value("t2_busy_after_start", busy, 1);
        num_frames = 8'd5;
        run(300, -1, -1, 0, 5);
        exp_g = {2, 2, 3, 2, 2};
        check_log("t2", 24, 2, 1, 2);

        // 3: continuous run ended by Stop mid-frame
        clear_log();
        pulse_start(8'd0);
        run(300, 6, -1, 0, -1);
        exp_g = {2, 2};
        check_log("t3", 12, 1, 1, 1);

        // 4a: hold mid-line after address 5
        clear_log();
        pulse_start(8'd1);
        run(300, -1, 5, 5, -1);
        exp_g = {2, 5, 2};
        check_log("t4a", 12, 1, 1, 1);

        // 4b: hold inside line blanking
        clear_log();
        pulse_start(8'd1);
        run(300, -1, 3, 3, -1);
        exp_g = {5, 2};
        check_log("t4b", 12, 1, 1, 1);

        // 5: reset mid-run at address 7, then a clean restart
        clear_log();
        pulse_start(8'd1);
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (rd_en && rd_addr == 14'd7) found = 1;
            else cycle();
        end
        check_value("t5_reached_addr7", found, 1);
        reset = 1'b1;
        cycle();
        check_all_zero("t5_after_reset");
        reset = 1'b0;
        repeat (4) cycle();
        check_value("t5_no_done", n_done, 0);
        check_value("t5_idle", busy, 0);
        clear_log();
        pulse_start(8'd1);
        check_value("t5_restart_fc", frame_count, 0);
        run(200, -1, -1, 0, -1);
        exp_g = {2, 2};
        check_log("t5", 12, 1, 1, 1);

        // 6: Start together with Stop in IDLE is refused
        clear_log();
        num_frames = 8'd1;
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        repeat (10) cycle();
        check_value("t6_no_rd", rd_q.size(), 0);
        check_value("t6_idle", busy, 0);
        check_value("t6_no_frame", n_frame, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
